// File: rtl/mc_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared encodings for the multi-cycle MIPS control path: FSM state codes,
// ALUOp codes, Op/Funct constants and the ALUSrcB / PCSource mux selects.
// Also provides the R-type Funct legality check used by the decoder.
// ----------------------------------------------------------------------------
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IF     = 4'd0,
        S_ID     = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXE    = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ORIEX  = 4'd10,
        S_ORIWB  = 4'd11
    } state_t;

    // ALUOp codes
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_OR  = 2'b10;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FUNCT_ADDU = 6'b100001;
    localparam logic [5:0] FUNCT_SUBU = 6'b100011;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;

    // ALU B operand select
    localparam logic [1:0] SRCB_REGB     = 2'b00;
    localparam logic [1:0] SRCB_FOUR     = 2'b01;
    localparam logic [1:0] SRCB_IMM      = 2'b10;
    localparam logic [1:0] SRCB_IMM_SHL2 = 2'b11;

    // Next-PC select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic is_legal_funct(input logic [5:0] funct);
        return (funct == FUNCT_ADDU) || (funct == FUNCT_SUBU) || (funct == FUNCT_OR);
    endfunction

endpackage

// File: rtl/mc_ctrl_alu_ctrl.sv
// ----------------------------------------------------------------------------
// alu_ctrl
// Combinational ALUOp generator. Maps the current control state plus the
// instruction's Op/Funct fields onto the 2-bit ALUOp (00 add, 01 sub, 10 or).
// Ports:
//   state  in  4 : current control state
//   Op     in  6 : IR[31:26]
//   Funct  in  6 : IR[5:0]
//   ALUOp  out 2 : ALU operation
// ----------------------------------------------------------------------------
module alu_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic [3:0] state,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    output logic [1:0] ALUOp
);

    // NOTE: combinational blocks use blocking assignments and give every
    // output a default first, so no path can leave a value held (no latch).
    always_comb begin
        ALUOp = ALU_ADD;
        case (state)
            S_EXE: begin
                if (Op == OP_RTYPE) begin
                    case (Funct)
                        FUNCT_SUBU: ALUOp = ALU_SUB;
                        FUNCT_OR:   ALUOp = ALU_OR;
                        default:    ALUOp = ALU_ADD;
                    endcase
                end
            end
            S_BRANCH: ALUOp = ALU_SUB;   // A - B drives the Zero compare
            S_ORIEX:  ALUOp = ALU_OR;
            default:  ALUOp = ALU_ADD;   // IF, ID, MEMADR address/PC adds
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// ----------------------------------------------------------------------------
// mc_ctrl
// Multi-cycle MIPS control unit. Holds the state register, decodes datapath
// selects/enables from the state (plus mem_rdy / Zero where noted), and
// counts retired instructions.
// Ports:
//   clk, rst (sync, active-high)
//   Op, Funct, Zero, mem_rdy           : decode and handshake inputs
//   PCWr IorD MemRd MemWr IRWr RegWr RegDst MemtoReg ALUSrcA ALUSrcB EXTOp
//   ALUOp PCSource                     : datapath controls
//   state                              : current state (debug)
//   instr_done, illegal                : one-cycle retire / decode-error pulses
//   instr_cnt                          : retired instruction count (wraps)
// ----------------------------------------------------------------------------
module mc_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  Op,
    input  logic [5:0]  Funct,
    input  logic        Zero,
    input  logic        mem_rdy,
    output logic        PCWr,
    output logic        IorD,
    output logic        MemRd,
    output logic        MemWr,
    output logic        IRWr,
    output logic        RegWr,
    output logic        RegDst,
    output logic        MemtoReg,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic        EXTOp,
    output logic [1:0]  ALUOp,
    output logic [1:0]  PCSource,
    output logic [3:0]  state,
    output logic        instr_done,
    output logic        illegal,
    output logic [31:0] instr_cnt
);

    state_t state_q;
    state_t state_d;

    alu_ctrl u_alu_ctrl (
        .state (state_q),
        .Op    (Op),
        .Funct (Funct),
        .ALUOp (ALUOp)
    );

    assign state = state_q;

    always_comb begin
        state_d    = S_IF;
        PCWr       = 1'b0;
        IorD       = 1'b0;
        MemRd      = 1'b0;
        MemWr      = 1'b0;
        IRWr       = 1'b0;
        RegWr      = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_REGB;
        EXTOp      = 1'b0;
        PCSource   = PCSRC_ALU;
        instr_done = 1'b0;
        illegal    = 1'b0;

        case (state_q)
            S_IF: begin
                // PC + 4 is computed every cycle; it only commits with the fetch.
                MemRd   = 1'b1;
                ALUSrcB = SRCB_FOUR;
                if (mem_rdy) begin
                    IRWr    = 1'b1;
                    PCWr    = 1'b1;
                    state_d = S_ID;
                end else begin
                    state_d = S_IF;
                end
            end
            S_ID: begin
                // Speculative branch target into ALUOut.
                ALUSrcB = SRCB_IMM_SHL2;
                EXTOp   = 1'b1;
                case (Op)
                    OP_RTYPE: begin
                        if (is_legal_funct(Funct)) state_d = S_EXE;
                        else                       illegal = 1'b1;
                    end
                    OP_ORI:        state_d = S_ORIEX;
                    OP_LW, OP_SW:  state_d = S_MEMADR;
                    OP_BEQ:        state_d = S_BRANCH;
                    OP_J:          state_d = S_JUMP;
                    default:       illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                EXTOp   = 1'b1;
                state_d = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                IorD    = 1'b1;
                MemRd   = 1'b1;
                state_d = mem_rdy ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                RegWr      = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                IorD  = 1'b1;
                MemWr = 1'b1;
                if (mem_rdy) instr_done = 1'b1;
                else         state_d    = S_MEMWR;
            end
            S_EXE: begin
                ALUSrcA = 1'b1;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegWr      = 1'b1;
                RegDst     = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                PCSource   = PCSRC_ALUOUT;
                PCWr       = Zero;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                PCSource   = PCSRC_JUMP;
                PCWr       = 1'b1;
                instr_done = 1'b1;
            end
            S_ORIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                state_d = S_ORIWB;
            end
            S_ORIWB: begin
                RegWr      = 1'b1;
                instr_done = 1'b1;
            end
            default: state_d = S_IF;
        endcase

        // Reset suppresses every side effect immediately, so an instruction
        // caught mid-flight (even mid memory wait) commits nothing.
        if (rst) begin
            PCWr       = 1'b0;
            IRWr       = 1'b0;
            RegWr      = 1'b0;
            MemWr      = 1'b0;
            MemRd      = 1'b0;
            instr_done = 1'b0;
            illegal    = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement or block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IF;
            instr_cnt <= 32'd0;
        end else begin
            state_q <= state_d;
            if (instr_done) instr_cnt <= instr_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mc_ctrl
// Directed bench for mc_ctrl. Each cycle the observed {state, controls} word
// is compared against hand-built expected words per state.
// Control word bit order (18 bits, MSB first):
//   PCWr IorD MemRd MemWr IRWr RegWr RegDst MemtoReg ALUSrcA ALUSrcB[1:0]
//   EXTOp ALUOp[1:0] PCSource[1:0] instr_done illegal
// ----------------------------------------------------------------------------
module tb_mc_ctrl;

    logic        clk;
    logic        rst;
    logic [5:0]  Op;
    logic [5:0]  Funct;
    logic        Zero;
    logic        mem_rdy;
    logic        PCWr, IorD, MemRd, MemWr, IRWr, RegWr, RegDst, MemtoReg, ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic        EXTOp;
    logic [1:0]  ALUOp;
    logic [1:0]  PCSource;
    logic [3:0]  state;
    logic        instr_done, illegal;
    logic [31:0] instr_cnt;

    mc_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .Op         (Op),
        .Funct      (Funct),
        .Zero       (Zero),
        .mem_rdy    (mem_rdy),
        .PCWr       (PCWr),
        .IorD       (IorD),
        .MemRd      (MemRd),
        .MemWr      (MemWr),
        .IRWr       (IRWr),
        .RegWr      (RegWr),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .EXTOp      (EXTOp),
        .ALUOp      (ALUOp),
        .PCSource   (PCSource),
        .state      (state),
        .instr_done (instr_done),
        .illegal    (illegal),
        .instr_cnt  (instr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    //                                  PCWr  IorD  MemRd MemWr IRWr  RegWr RegDst M2R   SrcA  SrcB   Ext   ALUOp  PCSrc  done  ill
    localparam logic [17:0] C_IF_RDY  = {1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,1'b0,2'b00,2'b00,1'b0,1'b0};
    localparam logic [17:0] C_IF_STL  = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,1'b0,2'b00,2'b00,1'b0,1'b0};
    localparam logic [17:0] C_ID      = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,1'b1,2'b00,2'b00,1'b0,1'b0};
    localparam logic [17:0] C_ID_ILL  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,1'b1,2'b00,2'b00,1'b0,1'b1};
    localparam logic [17:0] C_MEMADR  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,1'b1,2'b00,2'b00,1'b0,1'b0};
    localparam logic [17:0] C_MEMRD   = {1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,1'b0};
    localparam logic [17:0] C_MEMWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,1'b0,2'b00,2'b00,1'b1,1'b0};
    localparam logic [17:0] C_MEMWR_S = {1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,1'b0};
    localparam logic [17:0] C_MEMWR_R = {1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b1,1'b0};
    localparam logic [17:0] C_EXE_ADD = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,2'b00,2'b00,1'b0,1'b0};
    localparam logic [17:0] C_EXE_SUB = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,2'b01,2'b00,1'b0,1'b0};
    localparam logic [17:0] C_ALUWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b1,1'b0};
    localparam logic [17:0] C_BR_T    = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,2'b01,2'b01,1'b1,1'b0};
    localparam logic [17:0] C_BR_NT   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,2'b01,2'b01,1'b1,1'b0};
    localparam logic [17:0] C_JUMP    = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b10,1'b1,1'b0};
    localparam logic [17:0] C_ORIEX   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,1'b0,2'b10,2'b00,1'b0,1'b0};
    localparam logic [17:0] C_ORIWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b1,1'b0};

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_cnt = 32'd0;

    function automatic logic [21:0] obs();
        return {state, PCWr, IorD, MemRd, MemWr, IRWr, RegWr, RegDst, MemtoReg, ALUSrcA,
                ALUSrcB, EXTOp, ALUOp, PCSource, instr_done, illegal};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset state and combinational gating of enables while rst is high.
    task automatic test_reset();
        rst = 1'b1; mem_rdy = 1'b1; Op = 6'd0; Funct = 6'd0; Zero = 1'b0;
        tick();
        #1;
        n_cmp++;
        if (state !== 4'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state); end
        n_cmp++;
        if (instr_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_cnt: got %h want 0", instr_cnt); end
        n_cmp++;
        if ({PCWr, IRWr, MemRd, MemWr, RegWr, instr_done, illegal} !== 7'd0) begin
            n_bad++;
            $display("FAIL reset_gating: got %b want 0000000",
                     {PCWr, IRWr, MemRd, MemWr, RegWr, instr_done, illegal});
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (obs() !== {4'd0, C_IF_RDY}) begin n_bad++; $display("FAIL reset_release: got %h want %h", obs(), {4'd0, C_IF_RDY}); end
        mem_rdy = 1'b0;
        tick();
    endtask

    task automatic test_addu();
        logic [21:0] ex [4];
        ex = '{{4'd0, C_IF_RDY}, {4'd1, C_ID}, {4'd6, C_EXE_ADD}, {4'd7, C_ALUWB}};
        Op = 6'b000000; Funct = 6'b100001; mem_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++;
            if (obs() !== ex[i]) begin n_bad++; $display("FAIL addu cyc%0d: got %h want %h", i, obs(), ex[i]); end
            tick();
        end
        exp_cnt = 32'd1;
        n_cmp++;
        if ({state, instr_cnt} !== {4'd0, exp_cnt}) begin
            n_bad++; $display("FAIL addu_retire: got st=%0d cnt=%h want st=0 cnt=%h", state, instr_cnt, exp_cnt);
        end
    endtask

    task automatic test_subu();
        logic [21:0] ex [4];
        ex = '{{4'd0, C_IF_RDY}, {4'd1, C_ID}, {4'd6, C_EXE_SUB}, {4'd7, C_ALUWB}};
        Op = 6'b000000; Funct = 6'b100011; mem_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++;
            if (obs() !== ex[i]) begin n_bad++; $display("FAIL subu cyc%0d: got %h want %h", i, obs(), ex[i]); end
            tick();
        end
        exp_cnt = exp_cnt + 32'd1;
    endtask

    // lw stalled in MEMRD, then reset pulse: nothing commits, counter clears.
    task automatic test_reset_mid_access();
        logic [21:0] ex [3];
        ex = '{{4'd0, C_IF_RDY}, {4'd1, C_ID}, {4'd2, C_MEMADR}};
        Op = 6'b100011; Funct = 6'd0; mem_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (obs() !== ex[i]) begin n_bad++; $display("FAIL rstmid cyc%0d: got %h want %h", i, obs(), ex[i]); end
            tick();
        end
        mem_rdy = 1'b0;
        #1;
        n_cmp++;
        if (obs() !== {4'd3, C_MEMRD}) begin n_bad++; $display("FAIL rstmid_wait: got %h want %h", obs(), {4'd3, C_MEMRD}); end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({MemRd, RegWr, PCWr} !== 3'b000) begin n_bad++; $display("FAIL rstmid_gate: got %b want 000", {MemRd, RegWr, PCWr}); end
        tick();
        rst = 1'b0;
        #1;
        exp_cnt = 32'd0;
        n_cmp++;
        if ({state, RegWr, PCWr, instr_cnt} !== {4'd0, 1'b0, 1'b0, exp_cnt}) begin
            n_bad++;
            $display("FAIL rstmid_after: got st=%0d RegWr=%b PCWr=%b cnt=%h want st=0 0 0 cnt=0",
                     state, RegWr, PCWr, instr_cnt);
        end
        tick();
    endtask

    task automatic test_beq();
        logic [21:0] ex [6];
        logic        zz [6];
        ex = '{{4'd0, C_IF_RDY}, {4'd1, C_ID}, {4'd8, C_BR_T},
               {4'd0, C_IF_RDY}, {4'd1, C_ID}, {4'd8, C_BR_NT}};
        zz = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        Op = 6'b000100; Funct = 6'd0; mem_rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            Zero = zz[i];
            #1;
            n_cmp++;
            if (obs() !== ex[i]) begin n_bad++; $display("FAIL beq cyc%0d: got %h want %h", i, obs(), ex[i]); end
            tick();
        end
        exp_cnt = exp_cnt + 32'd2;
        n_cmp++;
        if (instr_cnt !== exp_cnt) begin n_bad++; $display("FAIL beq_cnt: got %h want %h", instr_cnt, exp_cnt); end
        Zero = 1'b0;
    endtask

    // mem_rdy low in ID/MEMADR is ignored; low for the first 3 MEMRD cycles stalls.
    task automatic test_lw_stall();
        logic [21:0] ex [8];
        logic        rd [8];
        ex = '{{4'd0, C_IF_RDY}, {4'd1, C_ID}, {4'd2, C_MEMADR}, {4'd3, C_MEMRD},
               {4'd3, C_MEMRD}, {4'd3, C_MEMRD}, {4'd3, C_MEMRD}, {4'd4, C_MEMWB}};
        rd = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        Op = 6'b100011; Funct = 6'd0;
        for (int i = 0; i < 8; i++) begin
            mem_rdy = rd[i];
            #1;
            n_cmp++;
            if (obs() !== ex[i]) begin n_bad++; $display("FAIL lw cyc%0d: got %h want %h", i, obs(), ex[i]); end
            tick();
        end
        exp_cnt = exp_cnt + 32'd1;
        n_cmp++;
        if ({state, instr_cnt} !== {4'd0, exp_cnt}) begin
            n_bad++; $display("FAIL lw_retire: got st=%0d cnt=%h want st=0 cnt=%h", state, instr_cnt, exp_cnt);
        end
    endtask

    // sw with a fetch stall and a write stall.
    task automatic test_sw_stall();
        logic [21:0] ex [6];
        logic        rd [6];
        ex = '{{4'd0, C_IF_STL}, {4'd0, C_IF_RDY}, {4'd1, C_ID}, {4'd2, C_MEMADR},
               {4'd5, C_MEMWR_S}, {4'd5, C_MEMWR_R}};
        rd = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        Op = 6'b101011; Funct = 6'd0;
        for (int i = 0; i < 6; i++) begin
            mem_rdy = rd[i];
            #1;
            n_cmp++;
            if (obs() !== ex[i]) begin n_bad++; $display("FAIL sw cyc%0d: got %h want %h", i, obs(), ex[i]); end
            tick();
        end
        exp_cnt = exp_cnt + 32'd1;
        n_cmp++;
        if (instr_cnt !== exp_cnt) begin n_bad++; $display("FAIL sw_cnt: got %h want %h", instr_cnt, exp_cnt); end
    endtask

    // ori, then an illegal opcode, then an R-type with an unknown Funct.
    task automatic test_ori_illegal();
        logic [21:0] ex [8];
        logic [5:0]  op [8];
        ex = '{{4'd0, C_IF_RDY}, {4'd1, C_ID}, {4'd10, C_ORIEX}, {4'd11, C_ORIWB},
               {4'd0, C_IF_RDY}, {4'd1, C_ID_ILL}, {4'd0, C_IF_RDY}, {4'd1, C_ID_ILL}};
        op = '{6'b001101, 6'b001101, 6'b001101, 6'b001101,
               6'b111111, 6'b111111, 6'b000000, 6'b000000};
        Funct = 6'b000000; mem_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            Op = op[i];
            #1;
            n_cmp++;
            if (obs() !== ex[i]) begin n_bad++; $display("FAIL ori_ill cyc%0d: got %h want %h", i, obs(), ex[i]); end
            tick();
        end
        exp_cnt = exp_cnt + 32'd1;
        n_cmp++;
        if ({state, instr_cnt} !== {4'd0, exp_cnt}) begin
            n_bad++; $display("FAIL ill_cnt: got st=%0d cnt=%h want st=0 cnt=%h", state, instr_cnt, exp_cnt);
        end
    endtask

    // Preload the counter at FFFFFFFF, then retire a j.
    task automatic test_wrap();
        Op = 6'b000010; Funct = 6'd0; mem_rdy = 1'b1;
        #1;
        n_cmp++;
        if (obs() !== {4'd0, C_IF_RDY}) begin n_bad++; $display("FAIL wrap_if: got %h want %h", obs(), {4'd0, C_IF_RDY}); end
        tick();
        #1;
        n_cmp++;
        if (obs() !== {4'd1, C_ID}) begin n_bad++; $display("FAIL wrap_id: got %h want %h", obs(), {4'd1, C_ID}); end
        tick();
        force dut.instr_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.instr_cnt;
        n_cmp++;
        if (obs() !== {4'd9, C_JUMP}) begin n_bad++; $display("FAIL wrap_jump: got %h want %h", obs(), {4'd9, C_JUMP}); end
        tick();
        exp_cnt = 32'd0;
        n_cmp++;
        if ({state, instr_cnt} !== {4'd0, exp_cnt}) begin
            n_bad++; $display("FAIL wrap_cnt: got st=%0d cnt=%h want st=0 cnt=%h", state, instr_cnt, exp_cnt);
        end
    endtask

    initial begin
        rst = 1'b1; Op = 6'd0; Funct = 6'd0; Zero = 1'b0; mem_rdy = 1'b0;
        test_reset();
        test_addu();
        test_reset_mid_access();
        test_subu();
        test_beq();
        test_lw_stall();
        test_sw_stall();
        test_ori_illegal();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Safety net: the directed sequence is a few hundred cycles at most.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish want finish before 100000");
        $fatal(1);
    end

endmodule
